gray_port_arbiter: RTL and testbench
====================================

# gray_port_arbiter

Two-requester arbiter for the single-port grayscale image memory (16384 x 8-bit, 128x128 raster). It lets two pixel engines, such as the LBP engine and a second 3x3 filter engine, share the gray_req/gray_addr/gray_ready/gray_data port. Arbitration is round-robin with burst locking, so one engine can fetch a full 3x3 window uninterrupted. Read data is routed back to the engine that issued each accepted address.

## Interface

Parameters:
- ADDR_W, 14, memory address width
- DATA_W, 8, pixel width
- MAX_BURST, 9, accepted transfers after which the owner is re-arbitrated (range 1..255)

Ports (reset: reset, asynchronous, active-high; clock: clk):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- m_req  input  2  per-requester level request; held for the whole burst
- m_addr0  input  ADDR_W  requester 0 read address
- m_addr1  input  ADDR_W  requester 1 read address
- m_gnt  output  2  one-hot (or zero) registered grant
- m_rvalid  output  2  one-hot read-data strobe, registered
- m_rdata  output  DATA_W  equals gray_data, combinational pass-through
- gray_req  output  1  memory request, equals m_req[owner] & m_gnt[owner]
- gray_addr  output  ADDR_W  address of the granted requester; 0 when no grant
- gray_ready  input  1  memory accepts the address this cycle
- gray_data  input  DATA_W  read data, valid the cycle after acceptance

## Operation

- A transfer is accepted at a rising edge where gray_req=1 and gray_ready=1. The matching data is on gray_data during the following cycle.
- State machine:
  - IDLE: m_gnt=0. At the edge where m_req!=0, grant the winner and go to OWN.
  - OWN: the owner register holds the requester index.
- Round-robin: the priority pointer is last_owner. After reset, requester 0 wins a tie.
- Release from OWN happens at the edge where either of these is true:
  - m_req[owner]=0 (voluntary release), or
  - burst_cnt reaches MAX_BURST on an accepted transfer (forced release).
- At a release edge, re-arbitrate immediately among the current m_req, with the releasing requester at lowest priority. There is no dead cycle.
  - If the other requester is requesting, it takes the grant.
  - If only the releasing requester is still requesting (forced case), it keeps the grant and burst_cnt clears.
  - If nobody is requesting, go to IDLE.
- burst_cnt (8-bit) increments on each accepted transfer and clears on every grant change or re-grant.
- Read-return routing: rd_pend and rd_id are registered at each accepted transfer. m_rvalid[rd_id] equals rd_pend. Data for the last transfer of a burst therefore reaches the old owner even though the grant has already moved.
- A requester must not change its address while gray_req=1 and gray_ready=0. The arbiter does not check this.

## Timing

- Grant latency: the edge that samples m_req drives m_gnt high in the next cycle. gray_req can go high in that same cycle.
- Back-to-back throughput: one transfer per cycle while gray_ready=1. A 9-transfer window takes 9 cycles plus 1 grant cycle.
- m_rvalid is high for exactly one cycle, the cycle after each acceptance.
- gray_ready=0 stalls the transfer. The grant is held and burst_cnt does not advance.
- Reset values, applied immediately and asynchronously:
  - m_gnt=0, m_rvalid=0, rd_pend=0, burst_cnt=0, last_owner=1, state IDLE.
  - Consequently gray_req=0 and gray_addr=0.
- Reset mid-burst: the in-flight read is dropped and no m_rvalid is issued after reset release.
- Simultaneous first requests out of reset: requester 0 is granted first.

## Structure

- Shared package gray_arb_pkg holds: the state enum (IDLE, OWN), ADDR_W/DATA_W defaults, and the IMG_W=128 / IMG_PIXELS=16384 constants used by the engines.
- One sub-module, rr_pick2: a combinational 2-way round-robin picker. Inputs: req[1:0], last_owner. Outputs: winner index and any_req.
- The top level holds the state machine, burst counter, and read-return tracking.

## Test plan

- Single requester: m_req=01, 9 addresses 0,1,2,128,129,130,256,257,258, gray_ready=1.
  - Required: m_gnt=01 one cycle after m_req.
  - Required: 9 consecutive m_rvalid[0] pulses, each carrying the data for those addresses.
  - Required: m_gnt=00 after m_req drops.
- Contention: m_req=11 from reset.
  - Required: requester 0 owns 9 transfers, forced release, then requester 1 is granted with no gap cycle.
  - Required: the 9th data of requester 0 arrives on m_rvalid[0] in the first cycle of requester 1's grant.
- Stall: gray_ready low for 3 cycles in the middle of a burst.
  - Required: gray_addr stays stable, burst_cnt holds, no m_rvalid during the stall, and the burst completes with exactly 9 pulses.
- Forced re-grant: only requester 1 requests, for 20 transfers, with MAX_BURST=9.
  - Required: m_gnt stays 10 throughout.
  - Required: burst_cnt clears after transfers 9 and 18.
  - Required: 20 m_rvalid[1] pulses.
- Reset mid-burst: assert reset 1 cycle after the 4th acceptance.
  - Required: m_gnt=0 and m_rvalid=0 immediately, and no stray m_rvalid after release.
- Voluntary release: requester 0 drops m_req after 3 transfers while requester 1 is requesting.
  - Required: m_gnt goes from 01 to 10 at the next edge.

Source files
------------

// File: rtl/gray_arb_pkg.sv
// Shared types and constants for the grayscale image memory port arbiter
// and the pixel engines that sit behind it.
package gray_arb_pkg;

  localparam int unsigned GrayAddrW  = 14;
  localparam int unsigned GrayDataW  = 8;
  localparam int unsigned IMG_W      = 128;
  localparam int unsigned IMG_PIXELS = 16384;

  typedef enum logic {
    StIdle,
    StOwn
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: the requester that did not own
// last wins a tie.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner,
  output logic       any_req
);

  always_comb begin
    any_req = |req;
    winner  = (req[0] && req[1]) ? ~last_owner : req[1];
  end

endmodule

// File: rtl/gray_port_arbiter.sv
// Round-robin, burst-locking arbiter sharing the single-port grayscale memory
// between two pixel engines, with per-transfer read-return routing.
module gray_port_arbiter
  import gray_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = GrayAddrW,
  parameter int unsigned DATA_W    = GrayDataW,
  parameter int unsigned MAX_BURST = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        m_req,
  input  logic [ADDR_W-1:0] m_addr0,
  input  logic [ADDR_W-1:0] m_addr1,
  output logic [1:0]        m_gnt,
  output logic [1:0]        m_rvalid,
  output logic [DATA_W-1:0] m_rdata,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic              gray_ready,
  input  logic [DATA_W-1:0] gray_data
);

  localparam logic [7:0] MaxBurstB = 8'(MAX_BURST);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       rd_pend_q;
  logic       rd_id_q;

  logic       winner;
  logic       any_req;
  logic       accept;
  logic       release_now;
  logic [7:0] burst_inc;

  rr_pick2 u_pick (
    .req        (m_req),
    .last_owner (last_owner_q),
    .winner     (winner),
    .any_req    (any_req)
  );

  always_comb begin
    m_gnt     = 2'b00;
    gray_req  = 1'b0;
    gray_addr = '0;
    if (state_q == StOwn) begin
      m_gnt     = owner_q ? 2'b10 : 2'b01;
      gray_req  = m_req[owner_q];
      gray_addr = owner_q ? m_addr1 : m_addr0;
    end
    m_rvalid = rd_pend_q ? (rd_id_q ? 2'b10 : 2'b01) : 2'b00;
    m_rdata  = gray_data;
  end

  assign accept      = gray_req & gray_ready;
  assign burst_inc   = burst_cnt_q + 8'd1;
  assign release_now = (state_q == StOwn) &&
                       (!m_req[owner_q] || (accept && burst_inc == MaxBurstB));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d      = StOwn;
          owner_d      = winner;
          last_owner_d = winner;
          burst_cnt_d  = 8'd0;
        end
      end
      StOwn: begin
        if (release_now) begin
          // last_owner equals the releasing owner here, so it sinks to lowest priority.
          burst_cnt_d = 8'd0;
          if (any_req) begin
            owner_d      = winner;
            last_owner_d = winner;
          end else begin
            state_d = StIdle;
          end
        end else if (accept) begin
          burst_cnt_d = burst_inc;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= 8'd0;
      rd_pend_q    <= 1'b0;
      rd_id_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pend_q    <= accept;
      if (accept) begin
        rd_id_q <= owner_q;
      end
    end
  end

endmodule

// File: tb/tb_gray_port_arbiter.sv
// Self-checking bench for gray_port_arbiter: a directed table, hand-built
// corner sequences and random traffic against a behavioural model.
module tb_gray_port_arbiter;

  localparam int unsigned MB = 9;

  logic        clk;
  logic        reset;
  logic [1:0]  m_req;
  logic [13:0] m_addr0;
  logic [13:0] m_addr1;
  logic [1:0]  m_gnt;
  logic [1:0]  m_rvalid;
  logic [7:0]  m_rdata;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic        gray_ready;
  logic [7:0]  gray_data;

  gray_port_arbiter #(
    .ADDR_W    (14),
    .DATA_W    (8),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m_req      (m_req),
    .m_addr0    (m_addr0),
    .m_addr1    (m_addr1),
    .m_gnt      (m_gnt),
    .m_rvalid   (m_rvalid),
    .m_rdata    (m_rdata),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_ready (gray_ready),
    .gray_data  (gray_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input logic [13:0] a);
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  // Memory image: data for an accepted address appears the next cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) gray_data <= 8'h00;
    else if (gray_req && gray_ready) gray_data <= pix(gray_addr);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: owner index (-1 = nobody), priority pointer, burst
  // count and the single outstanding read.
  int         md_own, md_last, md_cnt, md_pid, md_accs;
  bit         md_pend;
  logic [7:0] md_pdata;
  int         rv0, rv1;
  logic [1:0] s_gnt, s_rv;

  function automatic int pick(input logic [1:0] r, input int last);
    if (r[1-last]) return 1 - last;
    return last;
  endfunction

  task automatic step();
    bit          greq, acc, rel;
    logic [13:0] addr;
    int          c;
    @(negedge clk);
    greq = (md_own >= 0) && m_req[md_own];
    addr = (md_own == 0) ? m_addr0 : (md_own == 1) ? m_addr1 : 14'd0;
    chk("gnt", int'(m_gnt), (md_own < 0) ? 0 : (1 << md_own));
    chk("gray_req", int'(gray_req), int'(greq));
    chk("gray_addr", int'(gray_addr), int'(addr));
    chk("rvalid", int'(m_rvalid), md_pend ? (1 << md_pid) : 0);
    if (md_pend) chk("rdata", int'(m_rdata), int'(md_pdata));
    chk("burst_cnt", int'(dut.burst_cnt_q), md_cnt);
    s_gnt = m_gnt;
    s_rv  = m_rvalid;
    if (m_rvalid[0]) rv0++;
    if (m_rvalid[1]) rv1++;
    acc = greq && gray_ready;
    @(posedge clk);
    md_pend  = acc;
    md_pid   = md_own;
    md_pdata = pix(addr);
    if (acc) md_accs++;
    if (md_own < 0) begin
      if (m_req != 2'b00) begin
        md_own  = pick(m_req, md_last);
        md_last = md_own;
        md_cnt  = 0;
      end
    end else begin
      c   = md_cnt + int'(acc);
      rel = !m_req[md_own] || (acc && c == MB);
      if (rel) begin
        md_cnt = 0;
        if (m_req == 2'b00) md_own = -1;
        else begin
          md_own  = pick(m_req, md_own);
          md_last = md_own;
        end
      end else md_cnt = c;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_gnt", int'(m_gnt), 0);
    chk("rst_rvalid", int'(m_rvalid), 0);
    chk("rst_gray_req", int'(gray_req), 0);
    chk("rst_gray_addr", int'(gray_addr), 0);
    md_own = -1; md_last = 1; md_cnt = 0; md_pend = 0; md_pid = 0; md_accs = 0;
    rv0 = 0; rv1 = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [13:0] a0;
    logic        greq;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [7:0]  rd;
  } vec_t;

  initial begin
    vec_t        tbl[12];
    logic [13:0] win[9];
    int          own0, stalls, guard;
    bit          found, gap;

    reset = 1'b1; m_req = 2'b00; m_addr0 = '0; m_addr1 = '0; gray_ready = 1'b1;
    #2;
    do_reset();

    // Single requester fetching a 3x3 window.
    win = '{14'd0, 14'd1, 14'd2, 14'd128, 14'd129, 14'd130, 14'd256, 14'd257, 14'd258};
    tbl[0] = '{2'b01, win[0], 1'b0, 2'b00, 2'b00, 8'h00};
    for (int i = 1; i <= 9; i++)
      tbl[i] = '{2'b01, win[i-1], 1'b1, 2'b01,
                 (i >= 2) ? 2'b01 : 2'b00, (i >= 2) ? pix(win[i-2]) : 8'h00};
    tbl[10] = '{2'b00, 14'd0, 1'b0, 2'b01, 2'b01, pix(win[8])};
    tbl[11] = '{2'b00, 14'd0, 1'b0, 2'b00, 2'b00, 8'h00};
    for (int i = 0; i < 12; i++) begin
      m_req = tbl[i].req; m_addr0 = tbl[i].a0; gray_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), int'(m_gnt), int'(tbl[i].gnt));
      chk($sformatf("tbl%0d_greq", i), int'(gray_req), int'(tbl[i].greq));
      chk($sformatf("tbl%0d_rvalid", i), int'(m_rvalid), int'(tbl[i].rv));
      if (tbl[i].rv != 2'b00)
        chk($sformatf("tbl%0d_rdata", i), int'(m_rdata), int'(tbl[i].rd));
      @(posedge clk);
      #1;
    end

    // Contention from reset: requester 0 bursts, then 1 with no gap.
    do_reset();
    m_req = 2'b11; m_addr1 = 14'h3000; own0 = 0; found = 0; gap = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      m_addr0 = 14'(14'h100 + md_accs);
      step();
      if (s_gnt == 2'b01) own0++;
      if (s_gnt == 2'b00 && own0 > 0) gap = 1;
      if (s_gnt == 2'b10) begin
        found = 1;
        chk("cont_rv_on_switch", int'(s_rv), 1);
        chk("cont_own0_cycles", own0, 9);
        chk("cont_rv0_count", rv0, 9);
        chk("cont_gap", int'(gap), 0);
      end
    end
    if (!found) chk("cont_timeout", 0, 1);

    // Stall of 3 cycles after the 4th transfer.
    do_reset();
    m_req = 2'b01; stalls = 0; guard = 0;
    while (md_accs < 9 && guard < 40) begin
      guard++;
      m_addr0 = 14'(200 + md_accs);
      if (md_accs == 4 && stalls < 3) begin
        gray_ready = 1'b0;
        stalls++;
      end else gray_ready = 1'b1;
      step();
      if (md_accs == 4 && stalls >= 2 && !gray_ready) chk("stall_no_rvalid", int'(s_rv), 0);
    end
    gray_ready = 1'b1; m_req = 2'b00;
    step(); step();
    chk("stall_rv0_count", rv0, 9);

    // Forced re-grant of a lone requester 1.
    do_reset();
    m_req = 2'b10;
    step();
    for (int i = 0; i < 20; i++) begin
      m_addr1 = 14'(500 + i);
      step();
      chk("regrant_gnt", int'(s_gnt), 2);
    end
    m_req = 2'b00;
    step();
    chk("regrant_gnt_last", int'(s_gnt), 2);
    step();
    chk("regrant_rv1_count", rv1, 20);

    // Reset one cycle after the 4th acceptance.
    do_reset();
    m_req = 2'b01; guard = 0;
    while (md_accs < 4 && guard < 20) begin
      guard++;
      m_addr0 = 14'(900 + md_accs);
      step();
    end
    step();
    do_reset();
    m_req = 2'b00;
    for (int i = 0; i < 4; i++) step();
    chk("midrst_no_rvalid", rv0 + rv1, 0);

    // Voluntary release while requester 1 waits.
    do_reset();
    m_req = 2'b11; guard = 0;
    while (md_accs < 3 && guard < 20) begin
      guard++;
      m_addr0 = 14'(40 + md_accs);
      step();
    end
    m_req = 2'b10;
    step();
    chk("vol_gnt_before", int'(s_gnt), 1);
    step();
    chk("vol_gnt_after", int'(s_gnt), 2);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) m_req = 2'($urandom_range(0, 3));
        if (!(gray_req && !gray_ready)) begin
          m_addr0 = 14'($urandom);
          m_addr1 = 14'($urandom);
        end
        gray_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
